// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // One FIFO entry: the received byte and the parity-error flag that came with it.
    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } uart_entry_t;

    // Increment that holds at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO. The head entry is read straight from the storage
// registers, so a word written in cycle N is visible at the output in N+1.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_W + 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks occupancy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: captures bytes on the receiver's data-ready rising
// edge, queues them for the host, and keeps overflow/error status plus an
// inter-frame idle-gap detector.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ERR_CNT_W  = 8,
    parameter int GAP_CYCLES = 1024,
    parameter int DROP_ERR   = 0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_ready,
    input  logic                   rx_error,
    input  logic                   rx_idle,
    output logic [7:0]             m_data,
    output logic                   m_err,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [ERR_CNT_W-1:0]   drop_cnt,
    output logic                   frame_gap,
    input  logic                   clr_status
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic             rx_ready_q;
    logic             write_event;
    logic             err_event;
    logic             store_req;
    logic             push;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;
    uart_entry_t      wr_entry;
    uart_entry_t      rd_entry;
    logic [GAP_W-1:0] idle_cnt;
    logic             armed;

    assign write_event = rx_ready & ~rx_ready_q;
    assign err_event   = write_event & rx_error;
    assign store_req   = write_event & ~((DROP_ERR != 0) & rx_error);
    assign pop         = m_valid & m_ready;
    assign push        = store_req & (~full | pop);
    assign drop        = store_req & full & ~pop;

    assign wr_entry.err  = rx_error;
    assign wr_entry.data = rx_data;
    assign m_data        = rd_entry.data;
    assign m_err         = rd_entry.err;
    assign m_valid       = ~empty;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(uart_entry_t))
    ) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // rx_ready history; resets high so a level held through reset is not a new byte.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rx_ready_q <= 1'b1;
        end else begin
            rx_ready_q <= rx_ready;
        end
    end

    // Sticky overflow and saturating counters; a same-cycle event beats clr_status.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            overflow <= 1'b0;
            err_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_status) begin
                overflow <= 1'b0;
            end

            if (clr_status) begin
                err_cnt <= err_event ? ERR_CNT_W'(1) : '0;
            end else if (err_event) begin
                err_cnt <= ERR_CNT_W'(sat_inc(32'(err_cnt), ERR_CNT_W));
            end

            if (clr_status) begin
                drop_cnt <= drop ? ERR_CNT_W'(1) : '0;
            end else if (drop) begin
                drop_cnt <= ERR_CNT_W'(sat_inc(32'(drop_cnt), ERR_CNT_W));
            end
        end
    end

    // Idle-gap detector: armed by each byte, fires once after GAP_CYCLES idle cycles.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            armed     <= 1'b0;
            idle_cnt  <= '0;
            frame_gap <= 1'b0;
        end else begin
            frame_gap <= 1'b0;
            if (write_event) begin
                armed    <= 1'b1;
                idle_cnt <= '0;
            end else if (armed && rx_idle) begin
                if (idle_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    frame_gap <= 1'b1;
                    armed     <= 1'b0;
                    idle_cnt  <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART receiver. It captures each received byte together with its parity-error flag on the receiver's data-ready edge, and stores it in a synchronous FIFO. It presents entries to the host on a valid/ready interface, keeps sticky overflow status and saturating error/drop counters, and flags inter-frame idle gaps.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
ERR_CNT_W, 8, width of the parity-error and drop counters
GAP_CYCLES, 1024, consecutive idle cycles after the last byte that constitute a frame gap
DROP_ERR, 0, 1 = bytes with a parity error are counted but not stored

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte from the receiver
rx_ready  in  1  receiver data-ready level (may be high for several cycles)
rx_error  in  1  parity error for the byte, valid with rx_ready
rx_idle  in  1  receiver line-idle flag
m_data  out  8  head-of-FIFO byte
m_err  out  1  parity flag stored with the head entry
m_valid  out  1  FIFO not empty
m_ready  in  1  consumer accepts the head entry
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a byte was dropped because the FIFO was full
err_cnt  out  ERR_CNT_W  saturating count of bytes received with rx_error=1
drop_cnt  out  ERR_CNT_W  saturating count of bytes lost to a full FIFO
frame_gap  out  1  one-cycle pulse at the end of a frame (idle gap reached)
clr_status  in  1  pulse: clears overflow, err_cnt and drop_cnt

Behaviour:
- Reset (synchronous, active-high; clock Clk):
  - FIFO emptied; m_valid=0, level=0.
  - overflow=0, err_cnt=0, drop_cnt=0, frame_gap=0; idle counter and armed flag cleared.
  - rx_ready edge register resets to 1, so an rx_ready held high through reset is not captured.
- Capture: a write event occurs on the cycle where rx_ready=1 and the previous rx_ready=0. Only rising edges count; a level held high produces one event.
- On a write event:
  - If rx_error=1, err_cnt increments (saturating at all-ones), whether or not the byte is stored.
  - If DROP_ERR=1 and rx_error=1, nothing is stored.
  - Otherwise the byte is stored if not full, or if a pop occurs in the same cycle. Otherwise it is dropped, overflow is set and drop_cnt increments (saturating).
- Pop: occurs when m_valid && m_ready; the read pointer advances.
- Latency: a byte captured in cycle N shows m_valid=1 with that byte in cycle N+1 (registered). m_data and m_err are stable while m_valid=1 and no pop occurs.
- Simultaneous push and pop:
  - Not empty: level unchanged; both pointers advance.
  - Empty: no pop is possible, push only.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full is level==DEPTH; empty is level==0.
- clr_status: the cleared values take effect next cycle. If an overflow or error occurs in the same cycle as clr_status, the set/increment wins (overflow=1, counter=1).
- Gap detection:
  - The armed flag is set on any write event and cleared when frame_gap fires.
  - While armed and rx_idle=1, the idle counter increments; rx_idle=0 or a write event zeroes it.
  - When the counter reaches GAP_CYCLES, frame_gap pulses for one cycle and the detector disarms.
  - frame_gap never fires without an intervening byte.
- Reset mid-operation discards all stored data and status. A byte whose rx_ready edge coincides with Reset is discarded.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8; entry typedef {err, data[7:0]}; a saturating-increment function.
- One natural sub-module, uart_sync_fifo: parameterised DEPTH and width, push/pop/full/empty/level, registered output.
- Edge detection, counters and gap detection stay in the top of this block.

Test Plan:
1. Three bytes 0x41, 0x42, 0x43 with rx_error=0, m_ready=0 -> level=3, m_valid=1, m_data=0x41. Raising m_ready pops 0x41, 0x42, 0x43 on consecutive cycles; level returns to 0.
2. Hold rx_ready high for 5 cycles with byte 0x55 -> exactly one entry stored, level=1.
3. Fill 16 bytes, then send 0x99 with m_ready=0 -> overflow=1, drop_cnt=1, level=16, head unchanged. Next, 0x77 arriving in the same cycle as a pop -> stored, level stays 16, drop_cnt stays 1.
4. Byte 0xA5 with rx_error=1 and DROP_ERR=0 -> stored with m_err=1, err_cnt=1. Same with DROP_ERR=1 -> level stays 0, err_cnt=1.
5. After one byte, rx_idle=1 for GAP_CYCLES cycles -> frame_gap pulses once; with no further bytes, no further pulse. rx_idle dropping at GAP_CYCLES-1 -> no pulse.
6. Assert Reset with level=5, overflow=1 and rx_ready held high -> next cycle all outputs at reset values; releasing Reset with rx_ready still high -> no capture. clr_status in the same cycle as an overflow -> overflow=1, drop_cnt=1.
